// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter and sequencer for the shared 32-bit
// barrel shifter. It grants one request per cycle, drives the combinational
// shifter and captures its result in a single registered response stage
// tagged with the winner's ID. It also keeps a saturating operation counter.
//
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority.
module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    // requester 0 (ALU shift path)
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [SHAMT_W-1:0] req0_b,
    input  logic [1:0]         req0_ctr,
    // requester 1 (load/store byte alignment)
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [SHAMT_W-1:0] req1_b,
    input  logic [1:0]         req1_ctr,
    // shared combinational shifter
    output logic [DATA_W-1:0]  sh_a,
    output logic [SHAMT_W-1:0] sh_b,
    output logic [1:0]         sh_ctr,
    input  logic [DATA_W-1:0]  sh_d,
    // registered response
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_d,
    output logic               rsp_id,
    // performance debug
    output logic [CNT_W-1:0]   op_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_d;
    logic               r_rsp_id;
    logic [CNT_W-1:0]   r_op_cnt;
    logic               r_last;     // requester granted on the most recent accept

    logic               w_can_accept;
    logic               w_gnt;
    logic               w_accept;

    // The output stage can take a new result if it is empty or draining now.
    assign w_can_accept = !r_rsp_valid || rsp_ready;

    // Grant selection; requester 0 is the default when nobody is valid.
    always_comb begin
        // NOTE: assign a default first so every path drives w_gnt and no latch is inferred.
        w_gnt = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            w_gnt = !r_last;
        end else if (req1_valid) begin
            w_gnt = 1'b1;
        end
`else
        if (!req0_valid && req1_valid) begin
            w_gnt = 1'b1;
        end
`endif
    end

`ifndef SHIFT_ARB_RR_EN
    // Fixed priority still tracks the last winner, but never consults it.
    logic w_unused_last;
    assign w_unused_last = r_last;
`endif

    // Readies depend only on valids, last and the output stage, never on the
    // operand fields; they are held low while reset is asserted.
    assign req0_ready = !rst && w_can_accept && !w_gnt && req0_valid;
    assign req1_ready = !rst && w_can_accept &&  w_gnt && req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    // Route the granted requester's fields to the shared shifter.
    assign sh_a   = w_gnt ? req1_a   : req0_a;
    assign sh_b   = w_gnt ? req1_b   : req0_b;
    assign sh_ctr = w_gnt ? req1_ctr : req0_ctr;

    // Response stage, operation counter and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data register is reset as well because its value
            // after reset is visible on rsp_d; it is a single register, not a memory array.
            r_rsp_valid <= 1'b0;
            r_rsp_d     <= '0;
            r_rsp_id    <= 1'b0;
            r_op_cnt    <= '0;
            r_last      <= 1'b1;
        end else if (w_accept) begin
            // A new result replaces any draining one, so there is no bubble.
            r_rsp_valid <= 1'b1;
            r_rsp_d     <= sh_d;
            r_rsp_id    <= w_gnt;
            r_last      <= w_gnt;
            if (r_op_cnt != CNT_MAX) begin
                r_op_cnt <= r_op_cnt + CNT_ONE;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_d     = r_rsp_d;
    assign rsp_id    = r_rsp_id;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter. The bench supplies
// its own barrel shifter on sh_d. A negedge monitor predicts the readies and
// the response stream. Scenario tasks add direct checks against fixed values.
module tb_shift_arbiter;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0_valid = 1'b0;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_a = '0;
    logic [SHAMT_W-1:0] req0_b = '0;
    logic [1:0]         req0_ctr = '0;
    logic               req1_valid = 1'b0;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_a = '0;
    logic [SHAMT_W-1:0] req1_b = '0;
    logic [1:0]         req1_ctr = '0;
    logic [DATA_W-1:0]  sh_a;
    logic [SHAMT_W-1:0] sh_b;
    logic [1:0]         sh_ctr;
    logic [DATA_W-1:0]  sh_d;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [DATA_W-1:0]  rsp_d;
    logic               rsp_id;
    logic [CNT_W-1:0]   op_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_arbiter #(
        .DATA_W (DATA_W),
        .SHAMT_W(SHAMT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_ctr  (req0_ctr),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_ctr  (req1_ctr),
        .sh_a      (sh_a),
        .sh_b      (sh_b),
        .sh_ctr    (sh_ctr),
        .sh_d      (sh_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_d     (rsp_d),
        .rsp_id    (rsp_id),
        .op_cnt    (op_cnt)
    );

    // Reference barrel shifter: 00 arith right, 01 logical right, 1x left.
    function automatic logic [DATA_W-1:0] ref_shift(input logic [DATA_W-1:0] a,
                                                    input logic [SHAMT_W-1:0] b,
                                                    input logic [1:0] c);
        case (c)
            2'b00:   return $unsigned($signed(a) >>> b);
            2'b01:   return a >> b;
            default: return a << b;
        endcase
    endfunction

    always_comb sh_d = ref_shift(sh_a, sh_b, sh_ctr);

    function automatic logic model_gnt(input logic v0, input logic v1, input logic last);
`ifdef SHIFT_ARB_RR_EN
        if (v0 && v1) return !last;
        return v1;
`else
        if (v0) return 1'b0;
        return v1;
`endif
    endfunction

    // Monitor model state, updated at each negedge for the coming posedge.
    logic             m_valid = 1'b0;
    logic [CNT_W-1:0] m_cnt   = '0;
    logic             m_last  = 1'b1;
    logic             m_gnt, m_can, e_r0, e_r1;
    exp_t             m_e;

    // Predict the readies, the counter and the response stream, and score every cycle.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL mon_reset_ready: got %b%b expected 00", req0_ready, req1_ready);
            end
            sb.delete();
            m_valid = 1'b0;
            m_cnt   = '0;
            m_last  = 1'b1;
        end else begin
            m_gnt = model_gnt(req0_valid, req1_valid, m_last);
            m_can = !m_valid || rsp_ready;
            e_r0  = m_can && !m_gnt && req0_valid;
            e_r1  = m_can &&  m_gnt && req1_valid;
            checks++;
            if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
                failures++;
                $display("FAIL mon_ready: got %b%b expected %b%b", req0_ready, req1_ready, e_r0, e_r1);
            end
            checks++;
            if (rsp_valid !== m_valid) begin
                failures++;
                $display("FAIL mon_rsp_valid: got %b expected %b", rsp_valid, m_valid);
            end
            checks++;
            if (op_cnt !== m_cnt) begin
                failures++;
                $display("FAIL mon_op_cnt: got %h expected %h", op_cnt, m_cnt);
            end
            if (m_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL mon_sb_empty: got response %h with no expected entry", rsp_d);
                end else begin
                    m_e = sb.pop_front();
                    if ({rsp_id, rsp_d} !== {m_e.id, m_e.d}) begin
                        failures++;
                        $display("FAIL mon_rsp: got id=%b d=%h expected id=%b d=%h",
                                 rsp_id, rsp_d, m_e.id, m_e.d);
                    end
                end
            end
            if (e_r0 || e_r1) begin
                m_e.id = m_gnt;
                m_e.d  = m_gnt ? ref_shift(req1_a, req1_b, req1_ctr)
                               : ref_shift(req0_a, req0_b, req0_ctr);
                sb.push_back(m_e);
                m_valid = 1'b1;
                m_last  = m_gnt;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b id=%b expected 0 0", rsp_valid, rsp_id);
        end
        checks++;
        if (rsp_d !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp_d: got %h expected 00000000", rsp_d);
        end
        checks++;
        if (op_cnt !== 4'h0) begin
            failures++;
            $display("FAIL reset_op_cnt: got %h expected 0", op_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req0_a     = 32'hF2220023;
        req0_b     = 5'd4;
        req0_ctr   = 2'b01;
        req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_d !== 32'h0F222002) begin
            failures++;
            $display("FAIL single_rsp: got v=%b id=%b d=%h expected v=1 id=0 d=0f222002",
                     rsp_valid, rsp_id, rsp_d);
        end
        checks++;
        if (op_cnt !== 4'h1) begin
            failures++;
            $display("FAIL single_op_cnt: got %h expected 1", op_cnt);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_id;
        rst = 1'b1;
        step();
        rst        = 1'b0;
        rsp_ready  = 1'b1;
        req0_a     = 32'hF2220023; req0_b = 5'd4; req0_ctr = 2'b00;
        req1_a     = 32'h12220023; req1_b = 5'd4; req1_ctr = 2'b11;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
            exp_id = (i % 2 == 1);
`else
            exp_id = 1'b0;
`endif
            @(negedge clk);
            checks++;
            if (req1_ready !== exp_id) begin
                failures++;
                $display("FAIL contention_req1_ready[%0d]: got %b expected %b", i, req1_ready, exp_id);
            end
            step();
            checks++;
            if (rsp_id !== exp_id || rsp_d !== (exp_id ? 32'h22200230 : 32'hFF222002)) begin
                failures++;
                $display("FAIL contention_rsp[%0d]: got id=%b d=%h expected id=%b d=%h", i,
                         rsp_id, rsp_d, exp_id, exp_id ? 32'h22200230 : 32'hFF222002);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic              exp_id;
        logic [DATA_W-1:0] exp_d;
        req0_a = 32'h000000F0; req0_b = 5'd4; req0_ctr = 2'b01;
        req0_valid = 1'b1;
        rsp_ready  = 1'b0;
        step();
        req0_a = 32'h00000F00; req0_b = 5'd4;  req0_ctr = 2'b11;
        req1_a = 32'h00000001; req1_b = 5'd31; req1_ctr = 2'b11;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_d !== 32'h0000000F) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%b d=%h expected v=1 id=0 d=0000000f",
                         i, rsp_valid, rsp_id, rsp_d);
            end
            step();
        end
        rsp_ready = 1'b1;
`ifdef SHIFT_ARB_RR_EN
        exp_id = 1'b1;
        exp_d  = 32'h80000000;
`else
        exp_id = 1'b0;
        exp_d  = 32'h0000F000;
`endif
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== {!exp_id, exp_id}) begin
            failures++;
            $display("FAIL release_ready: got %b%b expected %b%b", req0_ready, req1_ready, !exp_id, exp_id);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_d !== exp_d) begin
            failures++;
            $display("FAIL release_rsp: got v=%b id=%b d=%h expected v=1 id=%b d=%h",
                     rsp_valid, rsp_id, rsp_d, exp_id, exp_d);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        rsp_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || op_cnt !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_state: got v=%b cnt=%h expected v=0 cnt=0", rsp_valid, op_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_first_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        step();
        checks++;
        if (rsp_id !== 1'b0 || rsp_d !== 32'h0000F000) begin
            failures++;
            $display("FAIL rst_mid_rsp: got id=%b d=%h expected id=0 d=0000f000", rsp_id, rsp_d);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        rst = 1'b1;
        step();
        rst        = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            req0_a     = $urandom;
            req0_b     = SHAMT_W'($urandom_range(0, 31));
            req0_ctr   = 2'($urandom_range(0, 3));
            req1_a     = $urandom;
            req1_b     = SHAMT_W'($urandom_range(0, 31));
            req1_ctr   = 2'($urandom_range(0, 3));
            req1_valid = 1'($urandom_range(0, 1));
            step();
            exp_cnt = (i + 1 >= 15) ? 4'hF : CNT_W'(i + 1);
            checks++;
            if (op_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL sat_op_cnt[%0d]: got %h expected %h", i, op_cnt, exp_cnt);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (op_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_hold: got %h expected f", op_cnt);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
